// File: rtl/pkg_en.sv
// Shared token types and widths for the external memory port.
package pkg_en;

    localparam int unsigned WIDTH_EXADDR = 16;
    localparam int unsigned WIDTH_DATA   = 32;
    localparam int unsigned WIDTH_IDX    = 8;
    localparam int unsigned WIDTH_EXLEN  = 16;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [WIDTH_IDX-1:0]  i;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic c;
    } BTk_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StStore,
        StDone
    } exmem_state_t;

endpackage

// File: rtl/exmem_ret_buf.sv
// Load return FIFO; its occupancy feeds the request credit check in the port.
module exmem_ret_buf
    import pkg_en::*;
#(
    parameter int unsigned DEPTH_BUF = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  FTk_t                       push_data,
    input  logic                       pop,
    output FTk_t                       head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH_BUF):0] occupancy
);

    localparam int unsigned AW = $clog2(DEPTH_BUF);
    localparam int unsigned OW = AW + 1;

    FTk_t          mem [DEPTH_BUF];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty = (occupancy == '0);
    assign full  = (occupancy == OW'(DEPTH_BUF));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_mem_port.sv
// Fabric-side load/store initiator for the external memory interface.
// Define EXMEM_IDX_EN to carry word addresses on FTk.i and check them on stores.
module ext_mem_port
    import pkg_en::*;
#(
    parameter int unsigned DEPTH_BUF = 4,
    parameter int unsigned WIDTH_LEN = WIDTH_EXLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Cmd_Valid,
    input  logic                    I_Cmd_St,
    input  logic [WIDTH_EXADDR-1:0] I_Cmd_Base,
    input  logic [WIDTH_LEN-1:0]    I_Cmd_Len,
    input  logic [WIDTH_EXADDR-1:0] I_Cmd_Stride,
    output logic                    O_Cmd_Ready,
    output logic                    O_Done,
    output logic                    O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
    input  FTk_t                    I_Ld_FTk,
    output BTk_t                    O_Ld_BTk,
    output FTk_t                    O_FTk,
    input  BTk_t                    I_BTk,
    input  FTk_t                    I_FTk,
    output BTk_t                    O_BTk,
    output logic                    O_St_Req,
    output logic [WIDTH_EXADDR-1:0] O_St_Addr,
    output FTk_t                    O_St_FTk,
    input  BTk_t                    I_St_BTk
);

    exmem_state_t                state;
    logic [WIDTH_EXADDR-1:0]     addr;
    logic [WIDTH_EXADDR-1:0]     stride;
    logic [WIDTH_LEN-1:0]        req_cnt;
    logic [WIDTH_LEN-1:0]        ret_cnt;
    logic                        inflight;
    FTk_t                        stage;
    FTk_t                        push_word;
    FTk_t                        cap_word;
    FTk_t                        head;
    logic                        push, pop, empty, full;
    logic [$clog2(DEPTH_BUF):0]  occupancy;
    logic                        ld_req, st_accept, st_open, idx_ok, capture;
`ifdef EXMEM_IDX_EN
    logic [WIDTH_EXADDR-1:0]     ld_addr_last;
    logic [WIDTH_EXADDR-1:0]     cap_addr;
    logic                        idx_err;
`endif

    exmem_ret_buf #(.DEPTH_BUF(DEPTH_BUF)) u_ret_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .occupancy (occupancy)
    );

    always_comb begin
        // Credit counts the word still in flight from last cycle's request.
        ld_req = (state == StLoad) && (req_cnt != '0) &&
                 ((32'(occupancy) + 32'(inflight)) < DEPTH_BUF);
        push = I_Ld_FTk.v && inflight;
        push_word   = '0;
        push_word.v = 1'b1;
        push_word.d = I_Ld_FTk.d;
        O_FTk = '0;
        if (!empty) begin
            O_FTk.v = 1'b1;
            O_FTk.d = head.d;
        end
`ifdef EXMEM_IDX_EN
        push_word.i = ld_addr_last[WIDTH_IDX-1:0];
        if (!empty) O_FTk.i = head.i;
`endif
        pop = O_FTk.v && !I_BTk.n;

        st_accept = (state == StStore) && stage.v && !I_St_BTk.n;
        st_open   = (state == StStore) && (req_cnt != '0) && (!stage.v || st_accept);
`ifdef EXMEM_IDX_EN
        cap_addr = stage.v ? addr + stride : addr;
        idx_ok   = (I_FTk.i == cap_addr[WIDTH_IDX-1:0]);
`else
        idx_ok   = 1'b1;
`endif
        capture    = st_open && I_FTk.v && idx_ok;
        cap_word   = '0;
        cap_word.v = 1'b1;
        cap_word.d = I_FTk.d;
`ifdef EXMEM_IDX_EN
        cap_word.i = I_FTk.i;
`endif
        O_BTk   = '0;
        O_BTk.n = (state == StStore) && !(st_open && idx_ok);
`ifdef EXMEM_IDX_EN
        O_BTk.c = idx_err;
`endif

        O_Ld_Req    = ld_req;
        O_Ld_Addr   = ld_req ? addr : '0;
        O_Ld_BTk    = '0;
        O_St_Req    = stage.v;
        O_St_Addr   = stage.v ? addr : '0;
        O_St_FTk    = stage;
        O_Cmd_Ready = (state == StIdle) && !reset;
        O_Done      = (state == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StIdle;
            addr     <= '0;
            stride   <= '0;
            req_cnt  <= '0;
            ret_cnt  <= '0;
            inflight <= 1'b0;
            stage    <= '0;
`ifdef EXMEM_IDX_EN
            ld_addr_last <= '0;
            idx_err      <= 1'b0;
`endif
        end else begin
            inflight <= ld_req;
`ifdef EXMEM_IDX_EN
            if (ld_req) ld_addr_last <= addr;
            if (st_open && I_FTk.v && !idx_ok) idx_err <= 1'b1;
`endif
            unique case (state)
                StIdle: begin
                    if (I_Cmd_Valid) begin
                        addr    <= I_Cmd_Base;
                        stride  <= I_Cmd_Stride;
                        req_cnt <= I_Cmd_Len;
                        ret_cnt <= I_Cmd_Len;
                        if (I_Cmd_Len == '0) state <= StDone;
                        else if (I_Cmd_St)   state <= StStore;
                        else                 state <= StLoad;
                    end
                end
                StLoad: begin
                    if (ld_req) begin
                        addr    <= addr + stride;
                        req_cnt <= req_cnt - 1'b1;
                    end
                    if (pop) ret_cnt <= ret_cnt - 1'b1;
                    if (req_cnt == '0) state <= StDrain;
                end
                StDrain: begin
                    if (pop) ret_cnt <= ret_cnt - 1'b1;
                    if (ret_cnt == '0) state <= StDone;
                end
                StStore: begin
                    if (capture) begin
                        stage   <= cap_word;
                        req_cnt <= req_cnt - 1'b1;
                    end else if (st_accept) begin
                        stage <= '0;
                    end
                    if (st_accept) begin
                        addr    <= addr + stride;
                        ret_cnt <= ret_cnt - 1'b1;
                    end
                    if ((ret_cnt == '0) && !stage.v) state <= StDone;
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{full, head, I_Ld_FTk, I_FTk, I_BTk, I_St_BTk};

endmodule

// File: tb/tb_ext_mem_port.sv
// Directed bench for ext_mem_port with a memory responder and a queue-based reference model.
module tb_ext_mem_port;
    import pkg_en::*;

    localparam int unsigned DEPTH_BUF = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic                    I_Cmd_Valid, I_Cmd_St;
    logic [WIDTH_EXADDR-1:0] I_Cmd_Base, I_Cmd_Stride;
    logic [WIDTH_EXLEN-1:0]  I_Cmd_Len;
    logic                    O_Cmd_Ready, O_Done, O_Ld_Req, O_St_Req;
    logic [WIDTH_EXADDR-1:0] O_Ld_Addr, O_St_Addr;
    FTk_t                    I_Ld_FTk, O_FTk, I_FTk, O_St_FTk;
    BTk_t                    O_Ld_BTk, I_BTk, O_BTk, I_St_BTk;

    ext_mem_port #(.DEPTH_BUF(DEPTH_BUF), .WIDTH_LEN(WIDTH_EXLEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Cmd_Valid  (I_Cmd_Valid),
        .I_Cmd_St     (I_Cmd_St),
        .I_Cmd_Base   (I_Cmd_Base),
        .I_Cmd_Len    (I_Cmd_Len),
        .I_Cmd_Stride (I_Cmd_Stride),
        .O_Cmd_Ready  (O_Cmd_Ready),
        .O_Done       (O_Done),
        .O_Ld_Req     (O_Ld_Req),
        .O_Ld_Addr    (O_Ld_Addr),
        .I_Ld_FTk     (I_Ld_FTk),
        .O_Ld_BTk     (O_Ld_BTk),
        .O_FTk        (O_FTk),
        .I_BTk        (I_BTk),
        .I_FTk        (I_FTk),
        .O_BTk        (O_BTk),
        .O_St_Req     (O_St_Req),
        .O_St_Addr    (O_St_Addr),
        .O_St_FTk     (O_St_FTk),
        .I_St_BTk     (I_St_BTk)
    );

    // Memory responder: one-cycle load latency, stores land when not nacked.
    logic [31:0] mem [0:1023];
    logic        mem_ready = 1'b0;
    logic        ld_ret = 1'b0;
    logic [31:0] ld_data = '0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
            mem_ready <= 1'b1;
        end else if (O_St_Req && !I_St_BTk.n) begin
            mem[O_St_Addr[9:0]] <= O_St_FTk.d;
        end
        ld_ret  <= O_Ld_Req;
        ld_data <= mem[O_Ld_Addr[9:0]];
    end
    always_comb begin
        I_Ld_FTk   = '0;
        I_Ld_FTk.v = ld_ret;
        I_Ld_FTk.d = ld_data;
    end

    int total = 0;
    int bad   = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model queues, filled when a command is issued.
    logic [15:0] exp_req[$];
    logic [15:0] exp_ld_a[$];
    logic [31:0] exp_ld_d[$];
    logic [15:0] exp_st_a[$];
    logic [31:0] exp_st_d[$];
    logic [31:0] st_src[$];

    int          cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          req_cyc[$];
    int          del_cyc[$];
    logic [31:0] del_d[$];
    int          st_req_n = 0, nack_n = 0, done_cnt = 0;
    int          outst = 0, max_outst = 0;
    logic        last_nack = 1'b0;
    logic [15:0] last_st_a = '0;
    logic [31:0] last_st_d = '0;

    always @(negedge clock) begin
        if (reset) begin
            exp_req.delete(); exp_ld_a.delete(); exp_ld_d.delete();
            exp_st_a.delete(); exp_st_d.delete();
            outst     = 0;
            last_nack = 1'b0;
        end else begin
            if (O_Ld_Req) begin
                req_cyc.push_back(cyc);
                if (exp_req.size() == 0) check("ld_req_unexpected", 1, 0);
                else check("ld_addr", O_Ld_Addr, exp_req.pop_front());
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
            if (O_FTk.v) begin
                check("ftk_arc", {O_FTk.a, O_FTk.r, O_FTk.c}, 3'b000);
            end else begin
                check("ftk_idle", O_FTk, '0);
            end
            if (O_FTk.v && !I_BTk.n) begin
                logic [15:0] a;
                del_cyc.push_back(cyc);
                del_d.push_back(O_FTk.d);
                outst--;
                if (exp_ld_d.size() == 0) begin
                    check("ld_data_unexpected", 1, 0);
                end else begin
                    check("ld_data", O_FTk.d, exp_ld_d.pop_front());
                    a = exp_ld_a.pop_front();
`ifdef EXMEM_IDX_EN
                    check("ld_idx", O_FTk.i, a[WIDTH_IDX-1:0]);
`else
                    check("ld_idx_zero", O_FTk.i, a[15:0] & 16'h0);
`endif
                end
            end
            if (O_St_Req) begin
                st_req_n++;
                if (last_nack) begin
                    check("st_hold_addr", O_St_Addr, last_st_a);
                    check("st_hold_data", O_St_FTk.d, last_st_d);
                end
                if (exp_st_a.size() == 0) begin
                    check("st_req_unexpected", 1, 0);
                end else begin
                    check("st_addr", O_St_Addr, exp_st_a[0]);
                    check("st_data", O_St_FTk.d, exp_st_d[0]);
                    if (!I_St_BTk.n) begin
                        void'(exp_st_a.pop_front());
                        void'(exp_st_d.pop_front());
                    end
                end
                if (I_St_BTk.n) nack_n++;
                last_nack = I_St_BTk.n;
                last_st_a = O_St_Addr;
                last_st_d = O_St_FTk.d;
            end else begin
                if (last_nack) check("st_req_hold", O_St_Req, 1'b1);
                last_nack = 1'b0;
            end
            if (O_Done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic st, input logic [15:0] base, input int len,
                         input logic [15:0] stride);
        logic [15:0] a;
        check("cmd_ready", O_Cmd_Ready, 1'b1);
        a = base;
        for (int k = 0; k < len; k++) begin
            if (!st) begin
                exp_req.push_back(a);
                exp_ld_a.push_back(a);
                exp_ld_d.push_back(mem[a[9:0]]);
            end else begin
                exp_st_a.push_back(a);
            end
            a = a + stride;
        end
        I_Cmd_Valid  = 1'b1;
        I_Cmd_St     = st;
        I_Cmd_Base   = base;
        I_Cmd_Len    = 16'(len);
        I_Cmd_Stride = stride;
        step();
        I_Cmd_Valid  = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int c = 0; c < budget && done_cnt == start; c++) step();
        check("done_seen", done_cnt != start, 1'b1);
        repeat (3) step();
        check("done_once", done_cnt, start + 1);
    endtask

    task automatic run_store(input logic [15:0] base, input logic [15:0] stride,
                             input int nack_word, input int nack_len);
        int   idx = 0;
        int   acc = 0;
        int   nk = 0;
        int   start = done_cnt;
        logic hs, an;
        foreach (st_src[k]) exp_st_d.push_back(st_src[k]);
        for (int c = 0; c < 80 && done_cnt == start; c++) begin
            I_FTk = '0;
            if (idx < st_src.size()) begin
                I_FTk.v = 1'b1;
                I_FTk.d = st_src[idx];
`ifdef EXMEM_IDX_EN
                I_FTk.i = WIDTH_IDX'(base + 16'(idx) * stride);
`else
                I_FTk.i = 8'hFF;
`endif
            end
            I_St_BTk   = '0;
            I_St_BTk.n = O_St_Req && (acc == nack_word) && (nk < nack_len);
            if (I_St_BTk.n) nk++;
            @(negedge clock);
            hs = I_FTk.v && !O_BTk.n;
            an = O_St_Req && !I_St_BTk.n;
            step();
            if (hs) idx++;
            if (an) acc++;
        end
        I_FTk    = '0;
        I_St_BTk = '0;
        wait_done(start, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int start, nreq, ndel, nst, nnk;
        reset = 1'b1;
        I_Cmd_Valid = 0; I_Cmd_St = 0; I_Cmd_Base = '0; I_Cmd_Len = '0; I_Cmd_Stride = '0;
        I_FTk = '0; I_BTk = '0; I_St_BTk = '0;
        step(); step();
        @(negedge clock);
        check("rst_ready", O_Cmd_Ready, 1'b0);
        check("rst_done", O_Done, 1'b0);
        check("rst_ldreq", {O_Ld_Req, O_Ld_Addr}, '0);
        check("rst_streq", {O_St_Req, O_St_Addr, O_St_FTk}, '0);
        check("rst_ftk", O_FTk, '0);
        check("rst_btk", {O_BTk, O_Ld_BTk}, '0);
        step();
        reset = 1'b0;
        #1;
        check("ready_after_rst", O_Cmd_Ready, 1'b1);

        // Load 0x10..0x13, stride 1, no stall.
        start = done_cnt; nreq = req_cyc.size(); ndel = del_cyc.size();
        issue(1'b0, 16'h0010, 4, 16'h0001);
        wait_done(start, 100);
        check("t1_nreq", req_cyc.size() - nreq, 4);
        check("t1_req_back2back", req_cyc[req_cyc.size()-1] - req_cyc[nreq], 3);
        check("t1_ndel", del_cyc.size() - ndel, 4);
        check("t1_del_back2back", del_cyc[del_cyc.size()-1] - del_cyc[ndel], 3);
        check("t1_first_word", del_d[ndel], 32'hC0DE_0010);
        check("t1_last_word", del_d[del_d.size()-1], 32'hC0DE_0013);

        // Load 8 words stride 2 with the fabric stalled for 10 cycles.
        start = done_cnt; nreq = req_cyc.size(); ndel = del_cyc.size();
        I_BTk.n = 1'b1;
        issue(1'b0, 16'h0000, 8, 16'h0002);
        repeat (10) step();
        check("t2_stall_nodel", del_cyc.size() - ndel, 0);
        I_BTk.n = 1'b0;
        wait_done(start, 100);
        check("t2_max_outstanding", max_outst, DEPTH_BUF);
        check("t2_nreq", req_cyc.size() - nreq, 8);
        check("t2_ndel", del_cyc.size() - ndel, 8);
        check("t2_last_word", del_d[del_d.size()-1], 32'hC0DE_000E);
        check("t2_model_empty", exp_ld_d.size(), 0);

        // Store A,B,C to 0x20 with the second word nacked twice.
        nst = st_req_n; nnk = nack_n;
        st_src = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        issue(1'b1, 16'h0020, 3, 16'h0001);
        run_store(16'h0020, 16'h0001, 1, 2);
        check("t3_mem20", mem[10'h020], 32'hAAAA_0001);
        check("t3_mem21", mem[10'h021], 32'hBBBB_0002);
        check("t3_mem22", mem[10'h022], 32'hCCCC_0003);
        check("t3_nacks", nack_n - nnk, 2);
        check("t3_streq_cycles", st_req_n - nst, 5);

        // Zero-length command.
        start = done_cnt; nreq = req_cyc.size(); nst = st_req_n;
        issue(1'b0, 16'h0060, 0, 16'h0001);
        @(negedge clock);
        check("t4_done_next", O_Done, 1'b1);
        check("t4_ready_low", O_Cmd_Ready, 1'b0);
        step();
        wait_done(start, 5);
        check("t4_no_ldreq", req_cyc.size() - nreq, 0);
        check("t4_no_streq", st_req_n - nst, 0);

        // Reset part-way through a 6-word load, then a clean 2-word load.
        ndel = del_cyc.size();
        issue(1'b0, 16'h0040, 6, 16'h0001);
        for (int c = 0; c < 50 && (del_cyc.size() - ndel) < 2; c++) step();
        check("t5_progress", (del_cyc.size() - ndel) >= 2, 1'b1);
        reset = 1'b1;
        step(); step();
        @(negedge clock);
        check("t5_rst_ready", O_Cmd_Ready, 1'b0);
        check("t5_rst_outs", {O_Ld_Req, O_St_Req, O_Done, O_BTk.n}, 4'b0000);
        check("t5_rst_ftk", O_FTk, '0);
        step();
        reset = 1'b0;
        #1;
        start = done_cnt; ndel = del_cyc.size();
        issue(1'b0, 16'h0050, 2, 16'h0001);
        wait_done(start, 100);
        check("t5_ndel", del_cyc.size() - ndel, 2);
        check("t5_last_word", del_d[del_d.size()-1], 32'hC0DE_0051);

`ifdef EXMEM_IDX_EN
        // Wrong index on a store is nacked and latches the error flag.
        issue(1'b1, 16'h0030, 1, 16'h0001);
        I_FTk   = '0;
        I_FTk.v = 1'b1;
        I_FTk.i = 8'h31;
        I_FTk.d = 32'hDEAD_BEEF;
        @(negedge clock);
        check("idx_nack", O_BTk.n, 1'b1);
        step();
        I_FTk = '0;
        @(negedge clock);
        check("idx_err", O_BTk.c, 1'b1);
        step();
        st_src = '{32'h3333_0030};
        run_store(16'h0030, 16'h0001, -1, 0);
        check("idx_mem30", mem[10'h030], 32'h3333_0030);
        check("idx_err_sticky", O_BTk.c, 1'b1);
`endif

        check("model_drained", exp_req.size() + exp_ld_d.size() + exp_st_a.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
